// File: rtl/arm7tdmi_jtag_pkg.sv
// Shared types, TMS sequences and helpers for the ARM7TDMI JTAG driver.
package arm7tdmi_jtag_pkg;

    typedef enum logic [1:0] {
        OP_RESET   = 2'd0,
        OP_IR_SCAN = 2'd1,
        OP_DR_SCAN = 2'd2,
        OP_IDLE    = 2'd3
    } jtag_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SHIFT,
        ST_TAIL,
        ST_RSP
    } drv_state_e;

    // TMS patterns, LSB is the first TCK of the sequence
    localparam logic [3:0] IR_HDR    = 4'b0011;
    localparam logic [2:0] DR_HDR    = 3'b001;
    localparam logic [1:0] TAIL      = 2'b01;
    localparam logic [5:0] RESET_SEQ = 6'b011111;

    // TMS value for header TCK number idx of the given operation
    function automatic logic hdr_tms(jtag_op_e op, logic [5:0] idx);
        logic [7:0] seq;
        case (op)
            OP_RESET:   seq = {2'b00, RESET_SEQ};
            OP_IR_SCAN: seq = {4'b0000, IR_HDR};
            OP_DR_SCAN: seq = {5'b00000, DR_HDR};
            default:    seq = 8'h00;
        endcase
        return (idx < 6'd8) ? seq[idx[2:0]] : 1'b0;
    endfunction

    // Index of the last header TCK; IDLE runs its whole count in the header
    function automatic logic [5:0] hdr_last(jtag_op_e op, logic [4:0] len);
        case (op)
            OP_RESET:   return 6'd5;
            OP_IR_SCAN: return 6'd3;
            OP_DR_SCAN: return 6'd2;
            default:    return {1'b0, len};
        endcase
    endfunction

endpackage

// File: rtl/arm7tdmi_jtag_tck_gen.sv
// TCK divider: tck level plus strobes flagging the clk edge where tck will rise/fall.
module arm7tdmi_jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int CW = $clog2(TCK_DIV) + 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last     = (cnt == CW'(TCK_DIV - 1));
    assign rise_evt = en & last & ~tck;
    assign fall_evt = en & last & tck;

    // Count half-periods while enabled; park low with a cleared count otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (last) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/arm7tdmi_jtag_driver.sv
// Command-driven JTAG master: RESET / IR_SCAN / DR_SCAN / IDLE, all ending in Run-Test/Idle.
module arm7tdmi_jtag_driver
    import arm7tdmi_jtag_pkg::*;
#(
    parameter int TCK_DIV = 2,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [4:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo,
    output logic              trst_n
);

    if (TCK_DIV < 1) begin : g_bad_div
        $error("TCK_DIV must be 1 or greater");
    end

    drv_state_e        state;
    jtag_op_e          op_q;
    logic [4:0]        len_q;
    logic [DATA_W-1:0] data_q;
    logic [5:0]        step;
    logic              en, rise_evt, fall_evt;

    assign en = (state == ST_HEADER) || (state == ST_SHIFT) || (state == ST_TAIL);

    arm7tdmi_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .tck      (tck),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt)
    );

    // Sequencer: tms/tdi advance on tck-fall edges, tdo captured on tck-rise edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            trst_n    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            op_q      <= OP_RESET;
            len_q     <= '0;
            data_q    <= '0;
            step      <= '0;
        end else begin
            trst_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= jtag_op_e'(cmd_op);
                        len_q     <= cmd_len;
                        data_q    <= cmd_data;
                        step      <= '0;
                        tms       <= hdr_tms(jtag_op_e'(cmd_op), 6'd0);
                        tdi       <= 1'b0;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b0;
                        state     <= ST_HEADER;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (fall_evt) begin
                        if (step == hdr_last(op_q, len_q)) begin
                            if (op_q == OP_RESET || op_q == OP_IDLE) begin
                                state     <= ST_IDLE;
                                cmd_ready <= 1'b1;
                            end else begin
                                state <= ST_SHIFT;
                                step  <= '0;
                                tms   <= (len_q == 5'd0);
                                tdi   <= data_q[0];
                            end
                        end else begin
                            step <= step + 6'd1;
                            tms  <= hdr_tms(op_q, step + 6'd1);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (rise_evt) begin
                        rsp_data[step[4:0]] <= tdo;
                    end
                    if (fall_evt) begin
                        if (step == {1'b0, len_q}) begin
                            state <= ST_TAIL;
                            step  <= '0;
                            tms   <= TAIL[0];
                            tdi   <= 1'b0;
                        end else begin
                            step <= step + 6'd1;
                            tms  <= ((step + 6'd1) == {1'b0, len_q});
                            tdi  <= data_q[step[4:0] + 5'd1];
                        end
                    end
                end
                ST_TAIL: begin
                    if (fall_evt) begin
                        if (step == 6'd1) begin
                            state     <= ST_RSP;
                            rsp_valid <= 1'b1;
                        end else begin
                            step <= 6'd1;
                            tms  <= TAIL[1];
                        end
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arm7tdmi_jtag_driver.sv
// Bench for arm7tdmi_jtag_driver: behavioural TAP on the pins, per-cycle model of the driver waveform.
module tb_arm7tdmi_jtag_driver;

    localparam int          D        = 2;
    localparam logic [31:0] IDCODE   = 32'h3F0F0F0F;
    localparam logic [3:0]  I_IDCODE = 4'hE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        tck, tms, tdi, tdo, trst_n;

    always #5 clk = ~clk;

    arm7tdmi_jtag_driver #(.TCK_DIV(D), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .trst_n(trst_n)
    );

    // ---------------- behavioural TAP (4-bit IR, IDCODE / bypass) ----------------
    typedef enum logic [3:0] {TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                              SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_e;
    tap_e        tap_st;
    logic [3:0]  tap_ir, ir_sr;
    logic [31:0] dr_sr;

    function automatic tap_e tap_next(tap_e s, logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDS  : RTI;
            SDS:  return m ? SIS  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDS  : RTI;
            SIS:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap_st <= TLR;
            tap_ir <= I_IDCODE;
            ir_sr  <= 4'd0;
            dr_sr  <= 32'd0;
        end else begin
            case (tap_st)
                TLR:  tap_ir <= I_IDCODE;
                CIR:  ir_sr  <= 4'b0001;
                SHIR: ir_sr  <= {tdi, ir_sr[3:1]};
                UIR:  tap_ir <= ir_sr;
                CDR:  dr_sr  <= (tap_ir == I_IDCODE) ? IDCODE : 32'd0;
                SHDR: if (tap_ir == I_IDCODE) dr_sr <= {tdi, dr_sr[31:1]};
                      else dr_sr <= {31'd0, tdi};
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck or negedge trst_n) begin
        if (!trst_n) tdo <= 1'b0;
        else tdo <= (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? dr_sr[0] : 1'b0;
    end

    int tck_rises = 0;
    always @(posedge tck) tck_rises++;

    // ---------------- checking ----------------
    int vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model of the current command
    bit          exp_tms[$];
    bit          exp_tdi[$];
    int          exp_n;
    bit          exp_scan;
    logic [31:0] exp_rsp;
    logic [3:0]  model_ir = I_IDCODE;
    int          cmd_seq = 0, seen_seq = 0, done_seq = 0, abort_seq = -1, n_cyc = 0;

    // Compare the pins against the model on every cycle of a running command
    always @(negedge clk) begin
        int k;
        if (cmd_seq != seen_seq) begin
            seen_seq = cmd_seq;
            n_cyc    = 0;
        end
        if (seen_seq != done_seq && seen_seq != abort_seq) begin
            if (n_cyc < 2 * D * exp_n) begin
                k = n_cyc / (2 * D);
                check("tck", tck, ((n_cyc % (2 * D)) >= D));
                check("tms", tms, exp_tms[k]);
                check("tdi", tdi, exp_tdi[k]);
                check("cmd_ready_busy", cmd_ready, 1'b0);
                check("rsp_valid_busy", rsp_valid, 1'b0);
            end else begin
                check("tck_end", tck, 1'b0);
                check("cmd_ready_end", cmd_ready, !exp_scan);
                check("rsp_valid_end", rsp_valid, exp_scan);
                if (exp_scan) check("rsp_data", rsp_data, exp_rsp);
                done_seq = seen_seq;
            end
            n_cyc++;
        end
    end

    // Build the expected TMS/TDI stream and response, then issue the command
    task automatic issue(input logic [1:0] op, input logic [4:0] len,
                         input logic [31:0] data, input bit wait_done, output int rises);
        int          L, w, r0;
        logic [63:0] sr;
        L = int'(len) + 1;
        exp_tms.delete();
        exp_tdi.delete();
        case (op)
            2'd0: exp_tms = '{1, 1, 1, 1, 1, 0};
            2'd1: exp_tms = '{1, 1, 0, 0};
            2'd2: exp_tms = '{1, 0, 0};
            default: for (int i = 0; i < L; i++) exp_tms.push_back(0);
        endcase
        for (int i = 0; i < exp_tms.size(); i++) exp_tdi.push_back(0);
        exp_scan = (op == 2'd1 || op == 2'd2);
        exp_rsp  = 32'd0;
        if (exp_scan) begin
            w  = (op == 2'd1) ? 4 : ((model_ir == I_IDCODE) ? 32 : 1);
            sr = (op == 2'd1) ? 64'd1 : ((w == 32) ? {32'd0, IDCODE} : 64'd0);
            for (int i = 0; i < L; i++) begin
                exp_tms.push_back(i == L - 1);
                exp_tdi.push_back(data[i]);
                exp_rsp[i] = sr[0];
                sr = sr >> 1;
                sr[w-1] = data[i];
            end
            exp_tms.push_back(1); exp_tdi.push_back(0);
            exp_tms.push_back(0); exp_tdi.push_back(0);
            if (op == 2'd1) model_ir = sr[3:0];
        end
        if (op == 2'd0) model_ir = I_IDCODE;
        exp_n = exp_tms.size();

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        for (int t = 0; t < 50 && !cmd_ready; t++) @(negedge clk);
        check("accept_timeout", cmd_ready, 1'b1);
        @(posedge clk);
        r0 = tck_rises;
        cmd_seq++;
        #1;
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        cmd_op    = 2'($urandom_range(0, 3));
        rises = 0;
        if (wait_done) begin
            for (int t = 0; t < 2 * D * exp_n + 20 && done_seq != cmd_seq; t++) begin
                @(negedge clk); #1;
            end
            check("done_timeout", (done_seq == cmd_seq), 1'b1);
            rises = tck_rises - r0;
            check("tck_count", rises, exp_n);
        end
    endtask

    // Hold the response for 'stall' cycles, then accept it
    task automatic consume(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_data", rsp_data, exp_rsp);
            check("stall_cmd_ready", cmd_ready, 1'b0);
            check("stall_tck", tck, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_clr", rsp_valid, 1'b0);
        check("ready_after_rsp", cmd_ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [1:0]  op;
        repeat (3) @(negedge clk);
        check("rst_tck", tck, 1'b0);
        check("rst_tms", tms, 1'b1);
        check("rst_tdi", tdi, 1'b0);
        check("rst_trst_n", trst_n, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("trst_n_release", trst_n, 1'b1);
        check("ready_after_rst", cmd_ready, 1'b1);

        // RESET: 6 TCKs, TAP lands in Run-Test/Idle
        issue(2'd0, 5'd0, 32'd0, 1, n);
        check("reset_tcks_lit", n, 6);
        check("tap_rti", (tap_st == RTI), 1'b1);

        // IR_SCAN 0xC, captured pattern 0001, with a 20-cycle response stall
        issue(2'd1, 5'd3, 32'hC, 1, n);
        check("ir_tcks_lit", n, 10);
        check("ir_rsp_lit", rsp_data, 32'h1);
        check("tap_ir_c", tap_ir, 4'hC);
        consume(20);

        // IDCODE read after RESET
        issue(2'd0, 5'd0, 32'd0, 1, n);
        issue(2'd2, 5'd31, 32'd0, 1, n);
        check("dr_tcks_lit", n, 37);
        check("idcode_lit", rsp_data, IDCODE);
        consume(0);

        // BYPASS delays the data by one bit
        issue(2'd1, 5'd3, 32'hF, 1, n);
        consume(0);
        issue(2'd2, 5'd7, 32'hA5, 1, n);
        check("bypass_lit", rsp_data, 32'h4A);
        consume(3);

        // IDLE op: L TCKs with tms=0
        issue(2'd3, 5'd4, 32'hFFFFFFFF, 1, n);
        check("idle_tcks_lit", n, 5);

        // randomized commands
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            issue(op, 5'($urandom_range(0, 31)), $urandom, 1, n);
            if (op == 2'd1 || op == 2'd2) consume($urandom_range(0, 4));
        end

        // reset in the middle of a DR scan, after 10 shift bits
        issue(2'd0, 5'd0, 32'd0, 1, n);
        issue(2'd2, 5'd31, $urandom, 0, n);
        repeat (2 * D * 13 + 1) @(negedge clk);
        #2;
        abort_seq = cmd_seq;
        rst = 1'b1;
        #1;
        check("abort_tck", tck, 1'b0);
        check("abort_tms", tms, 1'b1);
        check("abort_trst_n", trst_n, 1'b0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_tap_tlr", (tap_st == TLR), 1'b1);
        model_ir = I_IDCODE;
        repeat (3) @(negedge clk);
        check("abort_no_rsp", rsp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_trst_rel", trst_n, 1'b1);
        issue(2'd0, 5'd0, 32'd0, 1, n);
        issue(2'd1, 5'd3, 32'hC, 1, n);
        check("post_abort_ir_rsp", rsp_data, 32'h1);
        check("post_abort_tap_ir", tap_ir, 4'hC);
        consume(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arm7tdmi_jtag_driver.md
Name: arm7tdmi_jtag_driver

Overview:
- Command-driven JTAG master that generates tck/tms/tdi/trst_n for arm7tdmi_jtag_tap and captures its tdo.
- Sits directly upstream of the TAP. Debug-host logic and benches issue RESET, IR_SCAN, DR_SCAN and IDLE operations instead of hand-sequencing TMS.
- Every operation starts and ends with the TAP in Run-Test/Idle. TCK is derived from the system clock by a fixed divider.

Parameters:
- TCK_DIV, 2, system-clock cycles per TCK half-period; must be 1 or greater.
- DATA_W, 32, maximum scan length and width of the data and response fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  driver can accept a command.
- cmd_op  in  2  operation: 0=RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE.
- cmd_len  in  5  length minus 1. Scans: bits-1, giving 1..32. IDLE: TCK count-1.
- cmd_data  in  DATA_W  TDI bits, shifted LSB first; bits above the length are ignored.
- rsp_valid  out  1  scan result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  DATA_W  captured TDO bits; bit0 is the first bit shifted out; bits above the length read 0.
- tck  out  1  JTAG clock to the TAP.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data in.
- tdo  in  1  JTAG data out from the TAP.
- trst_n  out  1  TAP reset, registered.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, trst_n=0, rsp_valid=0, rsp_data=0, FSM=IDLE.
  - trst_n is driven to 1 on the first clk edge after rst deasserts.
  - cmd_ready=1 once out of reset.
- Reset mid-operation: the operation is aborted immediately, with no response. trst_n pulses low, so the TAP is forced to Test-Logic-Reset. The next command must be RESET.
- FSM states: IDLE, HEADER, SHIFT, TAIL, RSP.
  - cmd_ready=1 only in IDLE.
  - Handshake cmd_valid&cmd_ready moves IDLE to HEADER. RESET and IDLE ops skip directly to a single TMS-pattern sequence in HEADER.
- TMS sequences (one entry per TCK), with L = cmd_len+1:
  - RESET: 1,1,1,1,1,0. Total 6 TCK.
  - IR_SCAN: header 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR), then L shift bits with tms=0 except the last (tms=1, to Exit1-IR), then tail 1,0 (Update-IR, Run-Test/Idle). Total L+6 TCK.
  - DR_SCAN: header 1,0,0, then shift bits as for IR_SCAN, then tail 1,0. Total L+5 TCK.
  - IDLE: L TCK with tms=0 and tdi=0.
- TCK timing:
  - The command is accepted at edge 0. tms/tdi for TCK #1 are valid from edge 0.
  - tck rises at edge k·2·TCK_DIV − TCK_DIV and falls at edge k·2·TCK_DIV, for k=1..N.
  - tms/tdi change only on the clk edge where tck falls, so they are stable across every rising edge.
  - tck stays low when no operation is running.
- Data path:
  - tdi = cmd_data[i] during shift bit i; 0 outside shift bits.
  - tdo is sampled on the clk edge where tck rises, during shift bits only, into rsp_data[i].
- Completion, at the final tck-fall edge:
  - RESET/IDLE: return to IDLE, so cmd_ready=1 on the next cycle.
  - Scans: enter RSP with rsp_valid=1. rsp_data is held until rsp_valid&rsp_ready, then the FSM returns to IDLE.
- Ops and inputs outside the window:
  - cmd_valid while busy is ignored; the command remains pending and is held by the requester.
  - Illegal TCK_DIV=0 is a synthesis-time assertion failure.
- Counters:
  - Divider counter width is clog2(TCK_DIV)+1.
  - Bit counter is 6 bits, so L=32 does not wrap.
  - Total TCK counts above are exact; the bench counts tck edges against them.

Decomposition:
- arm7tdmi_jtag_pkg holds:
  - jtag_op_e (RESET/IR_SCAN/DR_SCAN/IDLE).
  - drv_state_e.
  - Header constants IR_HDR=4'b0011 (LSB first, length 4) and DR_HDR=3'b001 (length 3).
  - TAIL=2'b01.
  - RESET_SEQ=6'b011111 (LSB first).
- Sub-module arm7tdmi_jtag_tck_gen: divider counter that produces the tck level plus one-cycle rise_evt/fall_evt strobes; enable-gated.

Test Plan:
- Reset, then RESET op (cmd_op=0) -> exactly 6 tck rising edges, TMS sampled 1,1,1,1,1,0; TAP run_test_idle=1; cmd_ready high at edge 12·TCK_DIV.
- IR_SCAN, cmd_len=3, cmd_data=0xC -> 10 tck pulses; TAP current_ir==4'hC after completion; rsp_valid=1 with rsp_data=0x1 (IR capture pattern).
- After RESET, DR_SCAN with cmd_len=31 and cmd_data=0 -> 37 tck pulses; rsp_data equals the TAP's IDCODE constant.
- IR_SCAN with BYPASS (0xF), then DR_SCAN cmd_len=7 with cmd_data=0xA5 -> rsp_data=0x4A (input delayed by one bypass bit, first bit 0).
- Hold rsp_ready=0 for 20 cycles after a scan -> rsp_valid and rsp_data stable, cmd_ready=0, tck idle low. Asserting rsp_ready for 1 cycle then returns cmd_ready=1 on the next cycle.
- Assert rst midway through a DR_SCAN (after 10 shift bits) -> tck=0, tms=1, trst_n=0 the same cycle, no rsp_valid. A subsequent RESET plus IR_SCAN 0xC completes correctly.
